// File: rtl/shift_reg_sched.sv
// shift_reg_sched
//    Two-requester round-robin scheduler for one shared WIDTH-bit shift register.
//    An accepted word is loaded, shifted out LSB-first over WIDTH cycles, and
//    then followed by GAP forced idle cycles before the next grant.
//
// Ports
//    clock, reset        rising-edge clock, asynchronous active-high reset
//    reqN_valid/data     requester N offers a WIDTH-bit word
//    reqN_ready          requester N word is taken on this edge when valid&&ready
//    ser_out/ser_valid   serial data bit and its qualifier
//    ser_first/ser_last  current bit is bit 0 / bit WIDTH-1 of its word
//    owner               requester whose word is (or was last) shifted
//    busy                high while in SHIFT or GAP
//    reg_out             live shift-register contents
module shift_reg_sched #(
   parameter int WIDTH = 4,  // 2..16
   parameter int GAP   = 1   // 0..7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             owner,
   output logic             busy,
   output logic [WIDTH-1:0] reg_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reg_q, reg_d;
   logic [3:0]       cnt_q, cnt_d;      // bit index within the word, WIDTH <= 16
   logic [2:0]       gap_q, gap_d;      // idle cycles spent in GAP, GAP <= 7
   logic             owner_q, owner_d;
   logic             last_q, last_d;    // round-robin pointer: last granted requester

   logic gnt_valid;
   logic gnt_idx;
   logic accept;

   // Grant: a lone requester wins; on a tie the one not served last wins.
   // NOTE: every signal written in a combinational block gets a default first,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_valid = 1'b1;
         gnt_idx   = ~last_q;
      end else if (req0_valid) begin
         gnt_valid = 1'b1;
      end else if (req1_valid) begin
         gnt_valid = 1'b1;
         gnt_idx   = 1'b1;
      end
   end

   // Readies are held low while reset is asserted so nothing is handed over
   // to a register that is being cleared.
   assign accept     = (state_q == S_IDLE) && gnt_valid && !reset;
   assign req0_ready = accept && !gnt_idx;
   assign req1_ready = accept &&  gnt_idx;

   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               reg_d   = gnt_idx ? req1_data : req0_data;
               owner_d = gnt_idx;
               last_d  = gnt_idx;
               cnt_d   = 4'd0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Zero-fill from the top so reg_out reads 0 after the final bit.
            reg_d = {1'b0, reg_q[WIDTH-1:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(WIDTH - 1)) begin
               gap_d   = 3'd0;
               state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            gap_d = gap_q + 3'd1;
            if (gap_q == 3'(GAP - 1)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         reg_q   <= '0;
         cnt_q   <= 4'd0;
         gap_q   <= 3'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;  // requester 0 wins the first tie
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Serial outputs decode directly from state and registers; ser_out is
   // gated so it is a clean 0 whenever no bit is being presented.
   assign ser_valid = (state_q == S_SHIFT);
   assign ser_out   = ser_valid && reg_q[0];
   assign ser_first = ser_valid && (cnt_q == 4'd0);
   assign ser_last  = ser_valid && (cnt_q == 4'(WIDTH - 1));
   assign busy      = (state_q != S_IDLE);
   assign owner     = owner_q;
   assign reg_out   = reg_q;

endmodule

// File: tb/tb_shift_reg_sched.sv
// tb_shift_reg_sched
//    Directed bench: a row table drives the default WIDTH=4/GAP=1 instance one
//    cycle per row and compares every output; a hand-written sequence drives a
//    WIDTH=8/GAP=0 instance for back-to-back streaming.
module tb_shift_reg_sched;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // Default instance (WIDTH=4, GAP=1)
   logic       v0, v1, rdy0, rdy1;
   logic [3:0] d0, d1, rg;
   logic       so, sv, sf, sl, own, bsy;

   shift_reg_sched #(.WIDTH(4), .GAP(1)) u_dut (
      .clock(clock), .reset(reset),
      .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0),
      .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1),
      .ser_out(so), .ser_valid(sv), .ser_first(sf), .ser_last(sl),
      .owner(own), .busy(bsy), .reg_out(rg)
   );

   // Wide instance (WIDTH=8, GAP=0)
   logic       b_v0, b_v1, b_rdy0, b_rdy1;
   logic [7:0] b_d0, b_d1, b_rg;
   logic       b_so, b_sv, b_sf, b_sl, b_own, b_bsy;

   shift_reg_sched #(.WIDTH(8), .GAP(0)) u_dut8 (
      .clock(clock), .reset(reset),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_rdy0),
      .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_rdy1),
      .ser_out(b_so), .ser_valid(b_sv), .ser_first(b_sf), .ser_last(b_sl),
      .owner(b_own), .busy(b_bsy), .reg_out(b_rg)
   );

   typedef struct {
      logic       rst;
      logic       v0;
      logic [3:0] d0;
      logic       v1;
      logic [3:0] d1;
      logic [6:0] flags;  // {rdy0, rdy1, ser_out, ser_valid, ser_first, ser_last, busy}
      logic       own;
      logic [3:0] rg;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(logic rst, logic v0_i, logic [3:0] d0_i, logic v1_i,
                               logic [3:0] d1_i, logic [6:0] flags, logic own_i,
                               logic [3:0] rg_i);
      vec_t v;
      v.rst = rst; v.v0 = v0_i; v.d0 = d0_i; v.v1 = v1_i; v.d1 = d1_i;
      v.flags = flags; v.own = own_i; v.rg = rg_i;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [11:0] obs, exp;
      logic [7:0]  word8;
      logic        seen;

      v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
      b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0;

      // --- reset state
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      // --- single word 1011 from req0, then gap, then idle
      vecs.push_back(mk(0, 1, 4'hB, 0, 4'h0, 7'b1000000, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011101, 0, 4'hB));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011001, 0, 4'h5));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0001001, 0, 4'h2));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011011, 0, 4'h1));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000001, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      // --- both valid: readies stay low during reset, then 0,1,0 every 6 cycles
      vecs.push_back(mk(1, 1, 4'hA, 1, 4'h5, 7'b0000000, 0, 4'h0));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b1000000, 0, 4'h0));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0001101, 0, 4'hA));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0011001, 0, 4'h5));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0001001, 0, 4'h2));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0011011, 0, 4'h1));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0000001, 0, 4'h0));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0100000, 0, 4'h0));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0011101, 1, 4'h5));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0001001, 1, 4'h2));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0011001, 1, 4'h1));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0001011, 1, 4'h0));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b0000001, 1, 4'h0));
      vecs.push_back(mk(0, 1, 4'hA, 1, 4'h5, 7'b1000000, 1, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0001101, 0, 4'hA));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011001, 0, 4'h5));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0001001, 0, 4'h2));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011011, 0, 4'h1));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000001, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      // --- req1 alone (F) held through the word; tie at next idle goes to req0
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'hF, 7'b0100000, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'hF, 7'b0011101, 1, 4'hF));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'hF, 7'b0011001, 1, 4'h7));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'hF, 7'b0011001, 1, 4'h3));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'hF, 7'b0011011, 1, 4'h1));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'hF, 7'b0000001, 1, 4'h0));
      vecs.push_back(mk(0, 1, 4'h2, 1, 4'hF, 7'b1000000, 1, 4'h0));
      // --- reset during 2nd shift cycle of 0110 clears at once; req0 wins after
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      vecs.push_back(mk(0, 1, 4'h6, 0, 4'h0, 7'b1000000, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0001101, 0, 4'h6));
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      vecs.push_back(mk(0, 1, 4'h9, 1, 4'h3, 7'b1000000, 0, 4'h0));
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      // --- one-cycle req1 pulse while busy is ignored; no extra word follows
      vecs.push_back(mk(0, 1, 4'hC, 0, 4'h0, 7'b1000000, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0001101, 0, 4'hC));
      vecs.push_back(mk(0, 0, 4'h0, 1, 4'h7, 7'b0001001, 0, 4'h6));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011001, 0, 4'h3));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0011011, 0, 4'h1));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000001, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 7'b0000000, 0, 4'h0));

      // Inputs change 1 time unit after the rising edge; outputs are sampled
      // on the falling edge of the same cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clock);
         #1;
         reset = vecs[i].rst;
         v0 = vecs[i].v0; d0 = vecs[i].d0;
         v1 = vecs[i].v1; d1 = vecs[i].d1;
         @(negedge clock);
         obs = {rdy0, rdy1, so, sv, sf, sl, bsy, own, rg};
         exp = {vecs[i].flags, vecs[i].own, vecs[i].rg};
         check($sformatf("row%0d {rdy0,rdy1,so,sv,sf,sl,busy,own,reg}", i),
               32'(obs), 32'(exp));
      end

      // --- WIDTH=8, GAP=0: req0 streams C3 continuously
      @(posedge clock);
      #1;
      reset = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      word8 = 8'hC3;
      b_v0 = 1'b1; b_d0 = word8;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clock);
         if (b_rdy0) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL w8_first_accept: got no ready within 10 cycles expected ready");
      end else begin
         for (int i = 0; i < 18; i++) begin
            int k;
            logic [2:0] e;
            k = i % 9;
            e = (k < 8) ? {1'b0, 1'b1, word8[k]} : 3'b100;
            @(negedge clock);
            check($sformatf("w8_cycle%0d {rdy0,sv,so}", i),
                  32'({b_rdy0, b_sv, b_so}), 32'(e));
         end
      end
      b_v0 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_reg_sched.md
Name: shift_reg_sched

Overview:
- Two-requester scheduler and sequencer for one shared WIDTH-bit shift register.
- Each requester offers a parallel word through a valid/ready handshake.
- The block grants the register round-robin, loads the accepted word, shifts it out serially LSB-first over WIDTH cycles, and then enforces an inter-word gap.
- It sits between producer modules and a serial output link.

Parameters:
- WIDTH, 4, bits per word and shift-register width (legal 2..16).
- GAP, 1, idle cycles forced after each word's last bit (legal 0..7).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid&&ready.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid&&ready.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- ser_first  output  1  current bit is bit 0 of a word.
- ser_last  output  1  current bit is bit WIDTH-1 of a word.
- owner  output  1  requester index whose word is being shifted; holds its value outside SHIFT.
- busy  output  1  high in SHIFT or GAP.
- reg_out  output  WIDTH  live shift-register contents.

Behaviour:
- Reset (async, active-high): state=IDLE, reg_out=0, ser_out=0, ser_valid=0, ser_first=0, ser_last=0, owner=0, busy=0, bit counter=0, gap counter=0, rr pointer last=1 (requester 0 wins the first tie). Readies are 0 while reset is high.
- States:
  - IDLE: no shift in progress.
  - SHIFT: word being serialized.
  - GAP: mandatory idle after a word.
- Grant (combinational, IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last is granted.
  - reqN_ready = (state==IDLE) && grant==N. Never both high. Ready does not depend on the other requester's ready.
- Accept edge (IDLE, valid&&ready):
  - reg_out <= data; owner <= N; last <= N; bit counter <= 0; state <= SHIFT.
  - The requester may change data/valid from the next cycle.
- SHIFT (exactly WIDTH cycles):
  - ser_valid=1; ser_out=reg_out[0]; ser_first=(cnt==0); ser_last=(cnt==WIDTH-1).
  - Each edge: reg_out <= {1'b0, reg_out[WIDTH-1:1]}; cnt++.
  - The edge at cnt==WIDTH-1 goes to GAP, or to IDLE if GAP==0.
  - ser_out/ser_valid/ser_first/ser_last are combinational from state and registers. reg_out reads 0 after the final shift.
- GAP: ser_valid=0, ser_out=0, busy=1 for exactly GAP cycles, then IDLE.
- Latency: accept edge → first bit valid in the next cycle. Back-to-back throughput is one word per WIDTH+GAP+1 cycles.
- Valid dropped before acceptance: no effect, no grant. Valid held while busy: ready stays 0 and the word is held by the requester.
- Simultaneous valids on consecutive words: grants alternate 0,1,0,1 as long as both stay valid.
- Reset asserted mid-SHIFT or mid-GAP: immediate return to reset values. The partial word is dropped with no further ser_valid. The rr pointer returns to last=1.
- No X propagation: ser_out=0 whenever ser_valid=0.

Test Plan:
- Reset, then req0_valid=1 with req0_data=4'b1011 held one cycle → req0_ready=1 at that cycle. Next 4 cycles ser_out=1,1,0,1 with ser_valid=1, ser_first on cycle 1, ser_last on cycle 4, owner=0. Then 1 GAP cycle with busy=1, ser_valid=0, then IDLE.
- Both valid continuously, req0_data=4'hA, req1_data=4'h5 → accepts in order req0, req1, req0, req1. Serial stream 0,1,0,1 then 1,0,1,0 repeating. Accepts spaced exactly 6 cycles apart (GAP=1).
- req1 alone (4'hF), then both valid on the next IDLE → second grant goes to req0 (last=1). req1_ready stays 0 for the whole 4-cycle word plus gap.
- Reset pulsed high during the 2nd SHIFT cycle of 4'b0110 → outputs zero asynchronously with no remaining bits. After release with both valid, req0 is granted first.
- GAP=0, WIDTH=8, req0 valid continuously with 8'hC3 → ser_valid high 8 cycles, low 1 cycle (IDLE accept), high again. Bits 1,1,0,0,0,0,1,1.
- Valid pulsed high for one cycle while busy → no accept and no extra word on ser_out.
